move_arbiter: RTL and testbench

Sequencer that decides whether a player's single-pixel move is legal against a shared set of rectangles on the 640x480 playfield. It accepts one button request at a time and scans the rectangles through one shared overlap checker, one per cycle. It then issues either a move grant or a block, and keeps per-direction enable flags for the player-movement logic. It sits between the button decode and the player position register. The rectangle blocks supply their current positions and colors.

---
 rtl/game_pkg.sv | 26 ++
 rtl/move_arbiter_if.sv | 31 +++
 rtl/rect_overlap_check.sv | 28 ++
 rtl/move_arbiter.sv | 169 ++++++++++++++++
 tb/tb_move_arbiter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared playfield constants, direction encodings and the arbiter FSM state type.
package game_pkg;

  localparam logic [3:0] DIR_U = 4'd8;
  localparam logic [3:0] DIR_D = 4'd4;
  localparam logic [3:0] DIR_R = 4'd2;
  localparam logic [3:0] DIR_L = 4'd1;

  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned SCREEN_H    = 480;
  localparam int unsigned PLAYER_SIZE = 12;
  localparam int unsigned RECT_W      = 128;
  localparam int unsigned RECT_H      = 12;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StResult
  } state_e;

  // True only for exactly one of the four direction codes.
  function automatic logic is_single_dir(input logic [3:0] btns);
    return (btns == DIR_U) || (btns == DIR_D) || (btns == DIR_R) || (btns == DIR_L);
  endfunction

endpackage

// File: rtl/move_arbiter_if.sv
// Button/player/rectangle inputs and verdict outputs of the move arbiter.
interface move_arbiter_if #(
  parameter int unsigned NUM_RECTS = 4
);
  logic [3:0]              btns;
  logic [31:0]             player_hPos;
  logic [31:0]             player_vPos;
  logic [3:0]              player_color;
  logic [32*NUM_RECTS-1:0] rect_hPos;
  logic [32*NUM_RECTS-1:0] rect_vPos;
  logic [4*NUM_RECTS-1:0]  rect_color;

  logic                    busy;
  logic                    move_valid;
  logic [3:0]              move_dir;
  logic                    blocked;
  logic                    upEnable;
  logic                    downEnable;
  logic                    leftEnable;
  logic                    rightEnable;

  modport master (
    output btns, player_hPos, player_vPos, player_color, rect_hPos, rect_vPos, rect_color,
    input  busy, move_valid, move_dir, blocked, upEnable, downEnable, leftEnable, rightEnable
  );

  modport slave (
    input  btns, player_hPos, player_vPos, player_color, rect_hPos, rect_vPos, rect_color,
    output busy, move_valid, move_dir, blocked, upEnable, downEnable, leftEnable, rightEnable
  );
endinterface

// File: rtl/rect_overlap_check.sv
// Combinational overlap test of the candidate player square against one rectangle.
module rect_overlap_check #(
  parameter int unsigned RECT_W      = 128,
  parameter int unsigned RECT_H      = 12,
  parameter int unsigned PLAYER_SIZE = 12
) (
  input  logic [32:0] cand_h_i,
  input  logic [32:0] cand_v_i,
  input  logic [31:0] rect_h_i,
  input  logic [31:0] rect_v_i,
  input  logic [3:0]  rect_color_i,
  input  logic [3:0]  player_color_i,
  output logic        hit_o
);

  logic [32:0] rh, rv;
  logic        h_ovl, v_ovl;

  always_comb begin
    rh    = {1'b0, rect_h_i};
    rv    = {1'b0, rect_v_i};
    h_ovl = (cand_h_i < rh + 33'(RECT_W)) && (cand_h_i + 33'(PLAYER_SIZE) > rh);
    v_ovl = (cand_v_i < rv + 33'(RECT_H)) && (cand_v_i + 33'(PLAYER_SIZE) > rv);
    // Same-colored rectangles are passable.
    hit_o = h_ovl && v_ovl && (rect_color_i != player_color_i);
  end

endmodule

// File: rtl/move_arbiter.sv
// Evaluates one single-pixel move request at a time against screen edges and a set of
// rectangles scanned one per cycle through a shared overlap checker.
module move_arbiter
  import game_pkg::*;
#(
  parameter int unsigned NUM_RECTS   = 4,
  parameter int unsigned RECT_W      = game_pkg::RECT_W,
  parameter int unsigned RECT_H      = game_pkg::RECT_H,
  parameter int unsigned PLAYER_SIZE = game_pkg::PLAYER_SIZE,
  parameter int unsigned SCREEN_W    = game_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H    = game_pkg::SCREEN_H
) (
  input logic            btnClk,
  input logic            rst,
  move_arbiter_if.slave  bus
);

  localparam int unsigned IdxW = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1;

  state_e          state_q, state_d;
  logic [3:0]      dir_q, dir_d;
  logic [31:0]     ph_q, ph_d, pv_q, pv_d;
  logic [3:0]      pc_q, pc_d;
  logic            acc_q, acc_d;
  logic            edge_q, edge_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            blocked_q, blocked_d;
  // Enables packed {up, down, right, left} to line up with the direction codes.
  logic [3:0]      en_q, en_d;

  logic            edge_blk;
  logic [32:0]     cand_h, cand_v;
  logic [31:0]     sel_h, sel_v;
  logic [3:0]      sel_c;
  logic            hit;

  always_comb begin
    edge_blk = 1'b0;
    unique case (bus.btns)
      DIR_U:   edge_blk = (bus.player_vPos == 32'd0);
      DIR_L:   edge_blk = (bus.player_hPos == 32'd0);
      DIR_D:   edge_blk = ({1'b0, bus.player_vPos} + 33'(PLAYER_SIZE)) >= 33'(SCREEN_H);
      DIR_R:   edge_blk = ({1'b0, bus.player_hPos} + 33'(PLAYER_SIZE)) >= 33'(SCREEN_W);
      default: edge_blk = 1'b0;
    endcase
  end

  always_comb begin
    cand_h = {1'b0, ph_q};
    cand_v = {1'b0, pv_q};
    unique case (dir_q)
      DIR_U:   cand_v = {1'b0, pv_q} - 33'd1;
      DIR_D:   cand_v = {1'b0, pv_q} + 33'd1;
      DIR_L:   cand_h = {1'b0, ph_q} - 33'd1;
      DIR_R:   cand_h = {1'b0, ph_q} + 33'd1;
      default: ;
    endcase
  end

  always_comb begin
    sel_h = '0;
    sel_v = '0;
    sel_c = '0;
    for (int i = 0; i < int'(NUM_RECTS); i++) begin
      if (idx_q == IdxW'(i)) begin
        sel_h = bus.rect_hPos[32*i +: 32];
        sel_v = bus.rect_vPos[32*i +: 32];
        sel_c = bus.rect_color[4*i +: 4];
      end
    end
  end

  rect_overlap_check #(
    .RECT_W      (RECT_W),
    .RECT_H      (RECT_H),
    .PLAYER_SIZE (PLAYER_SIZE)
  ) u_overlap (
    .cand_h_i       (cand_h),
    .cand_v_i       (cand_v),
    .rect_h_i       (sel_h),
    .rect_v_i       (sel_v),
    .rect_color_i   (sel_c),
    .player_color_i (pc_q),
    .hit_o          (hit)
  );

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    ph_d      = ph_q;
    pv_d      = pv_q;
    pc_d      = pc_q;
    acc_d     = acc_q;
    edge_d    = edge_q;
    idx_d     = idx_q;
    valid_d   = 1'b0;
    blocked_d = 1'b0;
    en_d      = en_q;
    unique case (state_q)
      StIdle: begin
        if (is_single_dir(bus.btns)) begin
          dir_d   = bus.btns;
          ph_d    = bus.player_hPos;
          pv_d    = bus.player_vPos;
          pc_d    = bus.player_color;
          acc_d   = 1'b0;
          edge_d  = edge_blk;
          idx_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        acc_d = acc_q | hit;
        idx_d = idx_q + IdxW'(1);
        if (idx_q == IdxW'(NUM_RECTS - 1)) state_d = StResult;
      end
      StResult: begin
        if (acc_q || edge_q) begin
          blocked_d = 1'b1;
          en_d      = en_q & ~dir_q;
        end else begin
          valid_d = 1'b1;
          en_d    = en_q | dir_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge btnClk) begin
    if (rst) begin
      state_q   <= StIdle;
      dir_q     <= '0;
      ph_q      <= '0;
      pv_q      <= '0;
      pc_q      <= '0;
      acc_q     <= 1'b0;
      edge_q    <= 1'b0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      blocked_q <= 1'b0;
      en_q      <= 4'hf;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      ph_q      <= ph_d;
      pv_q      <= pv_d;
      pc_q      <= pc_d;
      acc_q     <= acc_d;
      edge_q    <= edge_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      blocked_q <= blocked_d;
      en_q      <= en_d;
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.move_valid  = valid_q;
  assign bus.blocked     = blocked_q;
  assign bus.move_dir    = dir_q;
  assign bus.upEnable    = en_q[3];
  assign bus.downEnable  = en_q[2];
  assign bus.rightEnable = en_q[1];
  assign bus.leftEnable  = en_q[0];

endmodule

// File: tb/tb_move_arbiter.sv
// Directed bench for move_arbiter with a verdict scoreboard checked by a pulse monitor.
module tb_move_arbiter;
  import game_pkg::*;

  localparam int unsigned NR = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  move_arbiter_if #(.NUM_RECTS(NR)) bus ();

  move_arbiter #(.NUM_RECTS(NR)) dut (
    .btnClk (clk),
    .rst    (rst),
    .bus    (bus)
  );

  typedef struct {
    logic       grant;
    logic [3:0] dir;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         pulse_cyc[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic [3:0] en_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] en_obs();
    return {bus.upEnable, bus.downEnable, bus.rightEnable, bus.leftEnable};
  endfunction

  always @(negedge clk) begin
    if (bus.move_valid === 1'b1 || bus.blocked === 1'b1) begin
      pulse_cyc.push_back(cyc);
      check("pulse_exclusive", 32'(bus.move_valid & bus.blocked), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'({bus.move_valid, bus.blocked}), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_grant", 32'(bus.move_valid), 32'(mon_e.grant));
        check("sb_blocked", 32'(bus.blocked), 32'(!mon_e.grant));
        check("sb_dir", 32'(bus.move_dir), 32'(mon_e.dir));
      end
    end
  end

  task automatic set_rect(input int i, input logic [31:0] h, input logic [31:0] v,
                          input logic [3:0] c);
    bus.rect_hPos[32*i +: 32] = h;
    bus.rect_vPos[32*i +: 32] = v;
    bus.rect_color[4*i +: 4]  = c;
  endtask

  task automatic set_player(input logic [31:0] h, input logic [31:0] v, input logic [3:0] c);
    bus.player_hPos  = h;
    bus.player_vPos  = v;
    bus.player_color = c;
  endtask

  // Called just after a negedge with the DUT idle.
  task automatic do_req(input string tag, input logic [3:0] dir, input logic grant);
    sb.push_back('{grant, dir});
    bus.btns = dir;
    @(posedge clk);
    #1 bus.btns = 4'd0;
    for (int i = 0; i < int'(NR) + 1; i++) begin
      @(negedge clk);
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    end
    @(negedge clk);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    check({tag, "_valid"}, 32'(bus.move_valid), 32'(grant));
    check({tag, "_blocked"}, 32'(bus.blocked), 32'(!grant));
    check({tag, "_dir"}, 32'(bus.move_dir), 32'(dir));
    if (grant) en_exp = en_exp | dir;
    else       en_exp = en_exp & ~dir;
    check({tag, "_en"}, 32'(en_obs()), 32'(en_exp));
    @(negedge clk);
    check({tag, "_pulse_len"}, 32'({bus.move_valid, bus.blocked}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    bus.btns = 4'd0;
    set_player(32'd100, 32'd100, 4'd1);
    for (int i = 0; i < int'(NR); i++) set_rect(i, 32'd400, 32'd300, 4'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    en_exp = 4'hf;

    @(negedge clk);
    check("rst_en", 32'(en_obs()), 32'hf);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.move_valid), 32'd0);
    check("rst_blocked", 32'(bus.blocked), 32'd0);
    check("rst_dir", 32'(bus.move_dir), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("idle_nobtn", 32'(bus.busy), 32'd0);
    end

    do_req("free_d", DIR_D, 1'b1);

    set_player(32'd100, 32'd88, 4'd5);
    set_rect(2, 32'd90, 32'd100, 4'd3);
    do_req("block_d", DIR_D, 1'b0);

    set_rect(2, 32'd90, 32'd100, 4'd5);
    do_req("pass_d", DIR_D, 1'b1);
    set_rect(2, 32'd400, 32'd300, 4'd0);

    set_player(32'd0, 32'd50, 4'd1);
    do_req("edge_l", DIR_L, 1'b0);
    set_player(32'd50, 32'd468, 4'd1);
    do_req("edge_d", DIR_D, 1'b0);
    set_player(32'd50, 32'd467, 4'd1);
    do_req("edge_d_ok", DIR_D, 1'b1);
    set_player(32'd628, 32'd50, 4'd1);
    do_req("edge_r", DIR_R, 1'b0);
    set_player(32'd627, 32'd50, 4'd1);
    do_req("edge_r_ok", DIR_R, 1'b1);
    set_player(32'd100, 32'd0, 4'd1);
    do_req("edge_u", DIR_U, 1'b0);
    set_player(32'd100, 32'd100, 4'd1);
    do_req("free_u", DIR_U, 1'b1);

    bus.btns = 4'b1100;
    repeat (4) begin
      @(negedge clk);
      check("multihot_idle", 32'(bus.busy), 32'd0);
    end
    bus.btns = 4'd0;

    // Reset lands while rect index 2 is being scanned.
    bus.btns = DIR_D;
    @(posedge clk);
    #1 bus.btns = 4'd0;
    @(posedge clk);
    @(negedge clk);
    check("midscan_busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    en_exp = 4'hf;
    @(negedge clk);
    check("midscan_rst_busy", 32'(bus.busy), 32'd0);
    check("midscan_rst_en", 32'(en_obs()), 32'hf);
    check("midscan_rst_dir", 32'(bus.move_dir), 32'd0);
    repeat (8) begin
      @(negedge clk);
      check("midscan_quiet", 32'({bus.busy, bus.move_valid, bus.blocked}), 32'd0);
    end

    pulse_cyc.delete();
    repeat (3) sb.push_back('{1'b1, DIR_U});
    bus.btns = DIR_U;
    repeat (13) @(posedge clk);
    #1 bus.btns = 4'd0;
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    repeat (8) @(negedge clk);
    check("held_drain", 32'(sb.size()), 32'd0);
    check("held_count", 32'(pulse_cyc.size()), 32'd3);
    if (pulse_cyc.size() == 3) begin
      check("held_gap1", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd6);
      check("held_gap2", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd6);
    end
    check("held_en", 32'(en_obs()), 32'hf);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
